// File: rtl/divergent_scheduler_if.sv
// rtl/divergent_scheduler_if.sv - scheduler-facing signal bundle for divergent_scheduler
// Purpose: groups the launch, decode, fetch, LSU and PC-unit inputs with the
//   core_state/current_pc/active_mask/diverged/done outputs of one block scheduler.
// Ports (slave view): in  start, thread_count, decoded_mem_read_enable,
//   decoded_mem_write_enable, decoded_ret, fetcher_state, lsu_state[T], next_pc[T];
//   out current_pc, active_mask, core_state, diverged, done,
//   divergence_count (only when DIVERGENCE_STATS_EN is defined).
interface divergent_scheduler_if #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8
);
  localparam int CW = $clog2(THREADS_PER_BLOCK) + 1;

  logic                                        start;
  logic [CW-1:0]                               thread_count;
  logic                                        decoded_mem_read_enable;
  logic                                        decoded_mem_write_enable;
  logic                                        decoded_ret;
  logic [2:0]                                  fetcher_state;
  logic [THREADS_PER_BLOCK-1:0][1:0]           lsu_state;
  logic [THREADS_PER_BLOCK-1:0][PC_WIDTH-1:0]  next_pc;
  logic [PC_WIDTH-1:0]                         current_pc;
  logic [THREADS_PER_BLOCK-1:0]                active_mask;
  logic [3:0]                                  core_state;
  logic                                        diverged;
  logic                                        done;
`ifdef DIVERGENCE_STATS_EN
  logic [15:0]                                 divergence_count;
`endif

  modport master (
`ifdef DIVERGENCE_STATS_EN
    input  divergence_count,
`endif
    output start, thread_count, decoded_mem_read_enable, decoded_mem_write_enable,
    output decoded_ret, fetcher_state, lsu_state, next_pc,
    input  current_pc, active_mask, core_state, diverged, done
  );

  modport slave (
`ifdef DIVERGENCE_STATS_EN
    output divergence_count,
`endif
    input  start, thread_count, decoded_mem_read_enable, decoded_mem_write_enable,
    input  decoded_ret, fetcher_state, lsu_state, next_pc,
    output current_pc, active_mask, core_state, diverged, done
  );
endinterface

// File: rtl/divergent_scheduler.sv
// rtl/divergent_scheduler.sv - per-block control-flow sequencer with per-thread PCs and min-PC reconvergence
// Purpose: keeps one PC per thread plus an active mask; threads on different
//   paths are run serially, lowest PC first, and rejoin when their PCs meet.
// Ports: clk (rising edge), reset (async, active low), bus (divergent_scheduler_if.slave).
// Optional: define DIVERGENCE_STATS_EN to add bus.divergence_count, a saturating
//   16-bit count of SELECT steps that issued only part of the live threads.
module divergent_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  divergent_scheduler_if.slave bus
);
  localparam int              T    = THREADS_PER_BLOCK;
  localparam int              CW   = $clog2(T) + 1;
  localparam logic [CW-1:0]   T_CW = CW'(T);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_REQUEST = 4'd3,
    S_WAIT    = 4'd4,
    S_EXECUTE = 4'd5,
    S_UPDATE  = 4'd6,
    S_SELECT  = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [T-1:0][PC_WIDTH-1:0]      r_thread_pc;
  logic [T-1:0]                    r_thread_done;
  logic [PC_WIDTH-1:0]             r_current_pc;
  logic [T-1:0]                    r_active_mask;
  logic                            r_diverged;
  logic                            r_done;

  logic [CW-1:0]                   w_n;
  logic [T-1:0]                    w_live;
  logic                            w_lsu_busy;
  logic                            w_found;
  logic [PC_WIDTH-1:0]             w_min;
  logic [T-1:0]                    w_sel_mask;
  logic                            w_sel_div;
  logic                            w_unused_mem;

  // Memory-op decode flags are carried for observability only; stalls come from lsu_state.
  assign w_unused_mem = bus.decoded_mem_read_enable ^ bus.decoded_mem_write_enable;

  // Requested thread counts above T are clamped to T.
  assign w_n = (bus.thread_count > T_CW) ? T_CW : bus.thread_count;

  always_comb begin
    w_live = '0;
    for (int i = 0; i < T; i++) begin
      w_live[i] = (CW'(i) < w_n);
    end
  end

  // Only LSUs of threads issuing the current instruction can hold the pipeline.
  always_comb begin
    w_lsu_busy = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (r_active_mask[i] && (bus.lsu_state[i] == 2'b01 || bus.lsu_state[i] == 2'b10)) begin
        w_lsu_busy = 1'b1;
      end
    end
  end

  // Min-PC selection. Non-live threads are marked done at launch, so thread_done
  // alone decides participation; w_found=0 means every live thread has returned.
  always_comb begin
    w_found    = 1'b0;
    w_min      = '0;
    w_sel_mask = '0;
    w_sel_div  = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (!r_thread_done[i] && (!w_found || r_thread_pc[i] < w_min)) begin
        w_min   = r_thread_pc[i];
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < T; i++) begin
      if (!r_thread_done[i]) begin
        if (r_thread_pc[i] == w_min) begin
          w_sel_mask[i] = 1'b1;
        end else begin
          w_sel_div = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_state_next = (w_n == '0) ? S_DONE : S_FETCH;
      S_FETCH:   if (bus.fetcher_state == 3'b010) w_state_next = S_DECODE;
      S_DECODE:  w_state_next = S_REQUEST;
      S_REQUEST: w_state_next = S_WAIT;
      S_WAIT:    if (!w_lsu_busy) w_state_next = S_EXECUTE;
      S_EXECUTE: w_state_next = S_UPDATE;
      S_UPDATE:  w_state_next = S_SELECT;
      S_SELECT:  w_state_next = w_found ? S_FETCH : S_DONE;
      S_DONE:    w_state_next = S_DONE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_thread_pc   <= '0;
      r_thread_done <= '0;
      r_current_pc  <= '0;
      r_active_mask <= '0;
      r_diverged    <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_thread_pc   <= '0;
            r_thread_done <= ~w_live;
            r_current_pc  <= '0;
            r_active_mask <= w_live;
            r_diverged    <= 1'b0;
            if (w_n == '0) r_done <= 1'b1;
          end
        end
        S_UPDATE: begin
          for (int i = 0; i < T; i++) begin
            if (r_active_mask[i]) begin
              if (bus.decoded_ret) begin
                r_thread_done[i] <= 1'b1;
              end else begin
                r_thread_pc[i] <= bus.next_pc[i];
              end
            end
          end
        end
        S_SELECT: begin
          if (!w_found) begin
            r_done        <= 1'b1;
            r_active_mask <= '0;
            r_diverged    <= 1'b0;
          end else begin
            r_current_pc  <= w_min;
            r_active_mask <= w_sel_mask;
            r_diverged    <= w_sel_div;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIVERGENCE_STATS_EN
  logic [15:0] r_div_count;

  // Partial issue is exactly the case where some non-done thread sits above the min PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_count <= '0;
    end else if (r_state == S_SELECT && w_found && w_sel_div && r_div_count != 16'hFFFF) begin
      r_div_count <= r_div_count + 16'd1;
    end
  end

  assign bus.divergence_count = r_div_count;
`endif

  assign bus.current_pc  = r_current_pc;
  assign bus.active_mask = r_active_mask;
  assign bus.core_state  = r_state;
  assign bus.diverged    = r_diverged;
  assign bus.done        = r_done;
endmodule

// File: tb/tb_divergent_scheduler.sv
// tb/tb_divergent_scheduler.sv - directed self-checking bench for divergent_scheduler
module tb_divergent_scheduler;
  localparam int T  = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset;
  int   scen;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stall_left;
  int   fetch_hold;
  logic [T-1:0][1:0] idle_pat;
  logic [T-1:0][1:0] stall_pat;

  always #5 clk = ~clk;

  divergent_scheduler_if #(.THREADS_PER_BLOCK(T), .PC_WIDTH(PW)) bus ();

  divergent_scheduler #(.THREADS_PER_BLOCK(T), .PC_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Program model: per-thread next PC and RET flag as a function of current_pc.
  always_comb begin
    bus.decoded_ret = 1'b0;
    for (int i = 0; i < T; i++) bus.next_pc[i] = bus.current_pc + 8'd1;
    case (scen)
      1: bus.decoded_ret = (bus.current_pc == 8'd3);
      2: begin
        if (bus.current_pc == 8'd2)
          for (int i = 0; i < T; i++) bus.next_pc[i] = (i < 2) ? 8'd3 : 8'd7;
        bus.decoded_ret = (bus.current_pc == 8'd8);
      end
      3: begin
        if (bus.current_pc == 8'd0)
          for (int i = 0; i < T; i++) bus.next_pc[i] = (i < 2) ? 8'd5 : 8'd9;
        bus.decoded_ret = (bus.current_pc == 8'd5) || (bus.current_pc == 8'd9);
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int pc, input int mask, input int div, input int dn);
    chk({tag, "_pc"},   32'(bus.current_pc),  32'(pc));
    chk({tag, "_mask"}, 32'(bus.active_mask), 32'(mask));
    chk({tag, "_div"},  32'(bus.diverged),    32'(div));
    chk({tag, "_done"}, 32'(bus.done),        32'(dn));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.lsu_state = '0;
    bus.fetcher_state = 3'b010;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic launch(input int n);
    bus.thread_count = 3'(n);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Runs one instruction from FETCH through SELECT, driving fetch and LSU stalls.
  task automatic step(output int cyc, output int waitc);
    logic [3:0] st;
    int n;
    n = 0; waitc = 0; st = bus.core_state;
    while (n < 200) begin
      st = bus.core_state;
      bus.fetcher_state = 3'b010;
      bus.lsu_state = idle_pat;
      if (st == 4'd1 && fetch_hold > 0) begin
        bus.fetcher_state = 3'b000;
        fetch_hold--;
      end
      if (st == 4'd4) begin
        waitc++;
        if (stall_left > 0) begin
          bus.lsu_state = stall_pat;
          stall_left--;
        end
      end
      @(posedge clk); #1;
      n++;
      if (st == 4'd7) break;
    end
    cyc = n;
    chk("step_reached_select", 32'(st == 4'd7), 32'd1);
  endtask

  int cyc, waitc;
  int exp_pc   [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 8};
  int exp_mask [9] = '{15, 15, 3, 3, 3, 3, 15, 15, 0};
  int exp_div  [9] = '{0, 0, 1, 1, 1, 1, 0, 0, 0};

  initial begin
    reset = 1'b0;
    scen = 1;
    bus.start = 1'b0;
    bus.thread_count = 3'd4;
    bus.decoded_mem_read_enable = 1'b0;
    bus.decoded_mem_write_enable = 1'b0;
    bus.fetcher_state = 3'b010;
    bus.lsu_state = '0;
    idle_pat = '0; stall_pat = '0; stall_left = 0; fetch_hold = 0;

    @(posedge clk); #1;
    chk("rst_state", 32'(bus.core_state), 32'd0);
    chk_out("rst", 0, 0, 0, 0);
    reset = 1'b1;

    // Uniform flow: 0,1,2,3 then RET.
    scen = 1;
    launch(4);
    chk("uni_state_fetch", 32'(bus.core_state), 32'd1);
    chk_out("uni0", 0, 15, 0, 0);
    step(cyc, waitc);
    chk("uni_latency", 32'(cyc), 32'd7);
    chk_out("uni1", 1, 15, 0, 0);
    fetch_hold = 3;
    step(cyc, waitc);
    chk("uni_fetch_stall_latency", 32'(cyc), 32'd10);
    chk_out("uni2", 2, 15, 0, 0);
    step(cyc, waitc);
    chk_out("uni3", 3, 15, 0, 0);
    step(cyc, waitc);
    chk_out("uni_end", 3, 0, 0, 1);
    chk("uni_state_done", 32'(bus.core_state), 32'd8);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("done_ignores_start", 32'(bus.core_state), 32'd8);

    // Divergence at PC 2, reconvergence at PC 7, with WAIT masking in the split.
    do_reset();
    scen = 2;
    launch(4);
    for (int k = 0; k < 9; k++) begin
      if (k == 3) idle_pat = 8'b10_00_00_00;
      if (k == 4) begin
        stall_pat = 8'b10_00_00_01;
        stall_left = 5;
      end
      step(cyc, waitc);
      if (k == 3) chk("wait_inactive_ignored", 32'(waitc), 32'd1);
      if (k == 4) chk("wait_stall_5", 32'(waitc), 32'd6);
      idle_pat = '0;
      chk_out($sformatf("div%0d", k), exp_pc[k], exp_mask[k], exp_div[k], (k == 8) ? 1 : 0);
`ifdef DIVERGENCE_STATS_EN
      if (k == 2) chk("stats_after_split", 32'(bus.divergence_count), 32'd1);
      if (k == 6) chk("stats_after_reconv", 32'(bus.divergence_count), 32'd4);
`endif
    end

    // Partial RET: threads 0,1 return at PC 5, threads 2,3 continue at PC 9.
    do_reset();
    scen = 3;
    launch(4);
    step(cyc, waitc);
    chk_out("pret5", 5, 3, 1, 0);
    step(cyc, waitc);
    chk_out("pret9", 9, 12, 0, 0);
    step(cyc, waitc);
    chk_out("pret_end", 9, 0, 0, 1);
    chk("pret_state", 32'(bus.core_state), 32'd8);

    // N=3 of 4: thread 3 never participates and does not count as divergent.
    do_reset();
    scen = 1;
    launch(3);
    chk_out("n3_start", 0, 7, 0, 0);
    step(cyc, waitc);
    chk_out("n3_pc1", 1, 7, 0, 0);
    for (int k = 0; k < 3; k++) step(cyc, waitc);
    chk_out("n3_end", 3, 0, 0, 1);

    // N above T is clamped.
    do_reset();
    launch(7);
    chk("n7_mask", 32'(bus.active_mask), 32'd15);

    // N=0 goes straight to DONE.
    do_reset();
    launch(0);
    chk("n0_state", 32'(bus.core_state), 32'd8);
    chk("n0_done", 32'(bus.done), 32'd1);
    chk("n0_mask", 32'(bus.active_mask), 32'd0);

    // Async reset while stalled in WAIT.
    do_reset();
    scen = 1;
    launch(4);
    step(cyc, waitc);
    bus.lsu_state = 8'b00_00_00_01;
    for (int k = 0; k < 20 && bus.core_state != 4'd4; k++) begin
      @(posedge clk); #1;
    end
    chk("ar_in_wait", 32'(bus.core_state), 32'd4);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_state", 32'(bus.core_state), 32'd0);
    chk_out("ar", 0, 0, 0, 0);
    bus.lsu_state = '0;
    @(posedge clk); #1;
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
